hamming_decode_engine: RTL

//  Downstream SECDED decoder stage for the (16,11) Hamming encoder: walks NUM_MSG encoded 16-bit words in data memory.
//  For each word it recomputes the syndrome and overall parity, corrects a single-bit error, and flags a double error.
//  It writes each 11-bit message plus 2 status flags back to data memory, then raises done.
//  It shares the single-port data memory (dm1) with the processor core and owns the memory port only while busy.

---
 rtl/hamming_decode_engine.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/hamming_decode_engine.sv
// ---------------------------------------------------------------------------
// hamming_decode_engine
//
// SECDED decoder stage for the (16,11) Hamming code. It walks NUM_MSG
// encoded 16-bit words stored as lo/hi byte pairs from SRC_BASE. For each
// word it:
//   - recomputes the syndrome and overall parity,
//   - corrects a single-bit error and flags a double error,
//   - writes {flags[1:0], 3'b000, d11..d1} back as a lo/hi byte pair
//     starting at DST_BASE.
// When the last word is written it raises done. The block shares a
// single-port data memory with the processor core and drives the memory
// port only while busy.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-high; forces IDLE and clears outputs
//   start        level; sampled only in IDLE and DONE
//   busy         high in every state except IDLE and DONE
//   done         high in DONE only
//   mem_addr     data-memory byte address (registered, held when idle)
//   mem_rd_data  read data, valid the cycle after mem_addr is presented
//   mem_wr_en    write strobe, high only in WR_LO / WR_HI
//   mem_wr_data  write data (0 outside the write states)
//   err1_count   words with a corrected single error, saturating
//   err2_count   words with a detected double error, saturating
// ---------------------------------------------------------------------------
module hamming_decode_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 30,
    parameter int DST_BASE = 0,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic [7:0]    err1_count,
    output logic [7:0]    err2_count
);

    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [AW-1:0] SRC_A = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A = AW'(DST_BASE);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, CAP_HI, DECODE, WR_LO, WR_HI, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [AW-1:0] addr_nxt;
    logic [AW-1:0] offset;
    logic          last_msg;
    logic          accept;

    logic [7:0]    lo_q, hi_q;
    logic [15:0]   word_q;

    logic [15:0]   cw, cw_fix, dec_word;
    logic [3:0]    syn;
    logic          par;
    logic [1:0]    flags;

    assign last_msg = (idx == IW'(NUM_MSG - 1));
    assign accept   = ((state == IDLE) || (state == DONE)) && start;

    // ------------------------------------------------------------------
    // Syndrome / parity check on the captured codeword
    // ------------------------------------------------------------------
    assign cw = {hi_q, lo_q};

    always_comb begin
        // NOTE: every variable written here gets a default first so no
        // path through the block can leave it unassigned and infer a latch.
        syn    = 4'd0;
        par    = ^cw;
        flags  = 2'b00;
        cw_fix = cw;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) syn = syn ^ 4'(k);
        end
        if (par) begin
            // Odd overall parity: exactly one bit flipped, syndrome names it.
            // syn == 0 means p0 itself flipped, which leaves the data intact.
            flags  = 2'b01;
            cw_fix = cw ^ (16'd1 << syn);
        end else if (syn != 4'd0) begin
            flags = 2'b10;
        end
        dec_word = {flags, 3'b000, cw_fix[15:9], cw_fix[7:5], cw_fix[3]};
    end

    // ------------------------------------------------------------------
    // Next-state, index and next memory address
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RD_LO;
                    idx_nxt   = '0;
                end
            end
            RD_LO:  state_nxt = RD_HI;
            RD_HI:  state_nxt = CAP_HI;
            CAP_HI: state_nxt = DECODE;
            DECODE: state_nxt = WR_LO;
            WR_LO:  state_nxt = WR_HI;
            WR_HI: begin
                if (last_msg) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RD_LO;
                    idx_nxt   = idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The address register is loaded with the address belonging to the
    // state being entered, so it is valid for the whole of that state.
    always_comb begin
        offset   = AW'({idx_nxt, 1'b0});
        addr_nxt = mem_addr;
        case (state_nxt)
            RD_LO:   addr_nxt = SRC_A + offset;
            RD_HI:   addr_nxt = SRC_A + offset + 1'b1;
            WR_LO:   addr_nxt = DST_A + offset;
            WR_HI:   addr_nxt = DST_A + offset + 1'b1;
            default: addr_nxt = mem_addr;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            mem_addr   <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            word_q     <= '0;
            err1_count <= '0;
            err2_count <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            mem_addr <= addr_nxt;
            if (state == RD_HI)  lo_q   <= mem_rd_data;
            if (state == CAP_HI) hi_q   <= mem_rd_data;
            if (state == DECODE) word_q <= dec_word;
            if (accept) begin
                err1_count <= '0;
                err2_count <= '0;
            end else if (state == DECODE) begin
                if (flags == 2'b01 && err1_count != 8'hFF) err1_count <= err1_count + 8'd1;
                if (flags == 2'b10 && err2_count != 8'hFF) err2_count <= err2_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the state register
    // ------------------------------------------------------------------
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign mem_wr_en = (state == WR_LO) || (state == WR_HI);

    always_comb begin
        mem_wr_data = 8'h00;
        if (state == WR_LO) mem_wr_data = word_q[7:0];
        if (state == WR_HI) mem_wr_data = word_q[15:8];
    end

endmodule
